hpu_cmd_tracker: RTL
====================

// Module: hpu_cmd_tracker
// PURPOSE
//  Per-HPU command front-end between one core's command port and the cluster command unit.
//  Allocates a local_cmd_id from a pool of NUM_HPU_CMDS slots and stamps the full pspin_cmd_id_t.
//  Registers the command toward the command unit and frees slots on matching pspin_cmd_resp_t.
//  Exposes per-ID completion and busy status for the HPU driver's wait/test calls.
// PARAMETERS
//  NUM_HPU_CMDS  4  slots / max in-flight commands (pspin_cfg_pkg::NUM_HPU_CMDS), power of 2
//  CLUSTER_ID    0  cluster_id stamped into cmd_id and matched on responses
//  CORE_ID       0  core_id stamped into cmd_id and matched on responses
// PORTS
//  clk_i             in   1                      clock
//  rst_i             in   1                      asynchronous reset, active-high
//  hpu_cmd_valid_i   in   1                      HPU issues a command
//  hpu_cmd_ready_o   out  1                      command accepted this cycle (valid&ready)
//  hpu_cmd_i         in   $bits(pspin_cmd_t)     command; incoming cmd_id field is ignored
//  hpu_cmd_id_o      out  $clog2(NUM_HPU_CMDS)   local_cmd_id assigned; valid when valid&ready
//  cmd_valid_o       out  1                      stamped command to command unit
//  cmd_ready_i       in   1                      command unit accepts
//  cmd_o             out  $bits(pspin_cmd_t)     stamped command
//  resp_valid_i      in   1                      completion broadcast from command unit
//  resp_i            in   $bits(pspin_cmd_resp_t) completion (cmd_id used, imm_data ignored)
//  check_id_i        in   $clog2(NUM_HPU_CMDS)   slot queried by HPU
//  check_done_o      out  1                      1 = queried slot is free (command complete)
//  busy_o            out  1                      1 = any slot allocated
//  num_inflight_o    out  $clog2(NUM_HPU_CMDS)+1 allocated slot count
//  err_spurious_o    out  1                      1-cycle pulse: unmatched/unallocated response
// BEHAVIOUR
//  State: alloc_q[NUM_HPU_CMDS], out_valid_q, out_cmd_q, out_noevt_q.
//   Reset: all 0, so cmd_valid_o=0, busy_o=0, num_inflight_o=0, err_spurious_o=0, check_done_o=1.
//  Allocation: free = ~alloc_q (registered state only).
//   hpu_cmd_id_o = lowest-index free slot; 0 when none is free.
//  hpu_cmd_ready_o = |free && (!out_valid_q || cmd_ready_i), combinational.
//   No dependence on hpu_cmd_valid_i.
//  Accept (valid&ready) in cycle N:
//   Set alloc_q[id] at N+1.
//   Load out_cmd_q = hpu_cmd_i with cmd_id = {CLUSTER_ID, CORE_ID, id}.
//   cmd_valid_o=1 from N+1; latency is exactly 1 cycle.
//  Output register holds cmd_o stable while cmd_valid_o && !cmd_ready_i (AXI-style, no drop).
//   Back-to-back accepts are allowed when cmd_ready_i=1 (full throughput).
//  Commands with generate_event=0 get no response.
//   Their slot is freed on the cycle cmd_valid_o && cmd_ready_i (clear at next edge).
//  Response match: resp_valid_i && cluster_id==CLUSTER_ID && core_id==CORE_ID.
//   Other core/cluster IDs are silently ignored (shared broadcast).
//  Matched response, slot allocated and not sitting in the output register:
//   clear alloc_q[local_cmd_id] at the next edge.
//  Matched response, slot unallocated or still in the output register:
//   no state change; err_spurious_o=1 for one cycle (registered, N+1).
//  Simultaneous events:
//   A slot freed in cycle N is not reallocatable until N+1 (ready uses registered alloc_q).
//   Accept, response-free and no-event-free may hit different slots in the same cycle;
//   all apply.
//  check_done_o = ~alloc_q[check_id_i], combinational.
//  busy_o = |alloc_q; num_inflight_o = popcount(alloc_q), both registered-state derived.
//  All slots allocated: hpu_cmd_ready_o=0, hpu_cmd_id_o=0, HPU stalls (no error).
//  Reset mid-operation: all slots freed and the pending output command dropped.
//   The command unit must be reset together.
// TESTING
//  1 Reset, then issue 1 cmd (generate_event=1), cmd_ready_i=1.
//    -> id 0; cmd_valid_o at +1 with cmd_id={CLUSTER_ID,CORE_ID,0}; busy_o=1; check(0)=0.
//  2 Issue 4 cmds, no responses.
//    -> ids 0,1,2,3; num_inflight_o=4; 5th request stalls with ready=0.
//    -> respond id 2; next request gets id 2 one cycle after the response.
//  3 cmd_ready_i=0 for 3 cycles after issue.
//    -> cmd_o stable, ready_o=0 while the register is full.
//    -> on release, cmd handshakes and the next cmd is accepted the same cycle.
//  4 Issue with generate_event=0.
//    -> slot 0 freed one cycle after the downstream handshake; num_inflight_o returns to 0.
//  5 Response with core_id != CORE_ID -> ignored, no err.
//    -> response for free slot 3 -> err_spurious_o pulse, alloc unchanged.
//  6 Assert rst_i with 3 slots allocated and cmd_valid_o=1.
//    -> all outputs at reset values immediately; next issue gets id 0.

Source files
------------

// File: rtl/hpu_cmd_tracker.sv
// ---------------------------------------------------------------------------
// pspin_cfg_pkg
//    Command and response formats shared between the HPU command front-end
//    and the cluster command unit. A cmd_id names one in-flight command
//    system-wide: {cluster_id, core_id, local_cmd_id}.
// ---------------------------------------------------------------------------
package pspin_cfg_pkg;

   localparam int NUM_HPU_CMDS = 4;
   localparam int CLUSTER_ID_W = 2;
   localparam int CORE_ID_W    = 3;
   localparam int LOCAL_ID_W   = $clog2(NUM_HPU_CMDS);

   typedef struct packed {
      logic [CLUSTER_ID_W-1:0] cluster_id;
      logic [CORE_ID_W-1:0]    core_id;
      logic [LOCAL_ID_W-1:0]   local_cmd_id;
   } pspin_cmd_id_t;

   typedef struct packed {
      pspin_cmd_id_t cmd_id;
      logic          generate_event;
      logic [1:0]    cmd_type;
      logic [31:0]   src_addr;
      logic [31:0]   dst_addr;
      logic [15:0]   length;
   } pspin_cmd_t;

   typedef struct packed {
      pspin_cmd_id_t cmd_id;
      logic [31:0]   imm_data;
   } pspin_cmd_resp_t;

endpackage

// ---------------------------------------------------------------------------
// hpu_cmd_tracker
//    Per-HPU command front-end. Hands out a local_cmd_id from a pool of
//    NUM_HPU_CMDS slots, stamps the full cmd_id into the command, registers
//    the command toward the cluster command unit and frees slots when the
//    matching completion comes back (or, for commands that raise no event,
//    as soon as the command unit takes them). Per-slot completion and a
//    global busy/in-flight count are exposed for the driver's wait/test.
//
// Ports
//    clk_i, rst_i       clock, asynchronous active-high reset
//    hpu_cmd_valid_i    HPU issues a command
//    hpu_cmd_ready_o    command accepted this cycle when valid is also high
//    hpu_cmd_i          command from the HPU (its cmd_id field is ignored)
//    hpu_cmd_id_o       local_cmd_id assigned to the accepted command
//    cmd_valid_o        stamped command toward the command unit
//    cmd_ready_i        command unit accepts
//    cmd_o              stamped command
//    resp_valid_i       completion broadcast from the command unit
//    resp_i             completion (only cmd_id is used)
//    check_id_i         slot queried by the HPU
//    check_done_o       queried slot is free
//    busy_o             any slot allocated
//    num_inflight_o     number of allocated slots
//    err_spurious_o     one-cycle pulse for a response that matched this
//                       core but named a slot that cannot complete
// ---------------------------------------------------------------------------
module hpu_cmd_tracker #(
   parameter int NUM_HPU_CMDS = pspin_cfg_pkg::NUM_HPU_CMDS,
   parameter int CLUSTER_ID   = 0,
   parameter int CORE_ID      = 0
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                hpu_cmd_valid_i,
   output logic                                hpu_cmd_ready_o,
   input  pspin_cfg_pkg::pspin_cmd_t           hpu_cmd_i,
   output logic [$clog2(NUM_HPU_CMDS)-1:0]     hpu_cmd_id_o,
   output logic                                cmd_valid_o,
   input  logic                                cmd_ready_i,
   output pspin_cfg_pkg::pspin_cmd_t           cmd_o,
   input  logic                                resp_valid_i,
   input  pspin_cfg_pkg::pspin_cmd_resp_t      resp_i,
   input  logic [$clog2(NUM_HPU_CMDS)-1:0]     check_id_i,
   output logic                                check_done_o,
   output logic                                busy_o,
   output logic [$clog2(NUM_HPU_CMDS):0]       num_inflight_o,
   output logic                                err_spurious_o
);

   localparam int ID_W  = $clog2(NUM_HPU_CMDS);
   localparam int CNT_W = ID_W + 1;

   typedef logic [pspin_cfg_pkg::LOCAL_ID_W-1:0]   local_id_t;
   typedef logic [pspin_cfg_pkg::CLUSTER_ID_W-1:0] cluster_id_t;
   typedef logic [pspin_cfg_pkg::CORE_ID_W-1:0]    core_id_t;

   localparam cluster_id_t MY_CLUSTER = cluster_id_t'(CLUSTER_ID);
   localparam core_id_t    MY_CORE    = core_id_t'(CORE_ID);

   logic [NUM_HPU_CMDS-1:0]   alloc_q;
   logic [NUM_HPU_CMDS-1:0]   alloc_d;
   logic [NUM_HPU_CMDS-1:0]   free_slots;
   logic [ID_W-1:0]           free_id;
   logic                      any_free;
   logic                      accept;
   logic                      out_fire;
   logic [ID_W-1:0]           out_id;
   logic [ID_W-1:0]           resp_id;
   logic                      resp_match;
   logic                      resp_in_out;
   logic                      resp_free;
   logic                      resp_err;
   logic                      out_valid_q;
   logic                      out_noevt_q;
   logic                      err_q;
   logic [CNT_W-1:0]          inflight;
   logic                      resp_unused;
   pspin_cfg_pkg::pspin_cmd_t out_cmd_q;
   pspin_cfg_pkg::pspin_cmd_t stamped_cmd;

   // Only the cmd_id of a response matters; the immediate data belongs to
   // the driver's event path, not to slot bookkeeping.
   assign resp_unused = ^resp_i.imm_data;

   // Free slots come from registered state only, so a slot released this
   // cycle is not handed out again until the following cycle. Scanning from
   // the top down leaves the lowest free index in free_id; with no free slot
   // the id reads as 0.
   always_comb begin
      free_slots = ~alloc_q;
      free_id    = '0;
      for (int i = NUM_HPU_CMDS - 1; i >= 0; i--) begin
         if (free_slots[i]) begin
            free_id = ID_W'(i);
         end
      end
   end

   // The HPU may issue whenever a slot is free and the output register is
   // empty or emptying this cycle, which gives full throughput while the
   // command unit keeps cmd_ready_i high.
   assign any_free        = |free_slots;
   assign hpu_cmd_ready_o = any_free && (!out_valid_q || cmd_ready_i);
   assign hpu_cmd_id_o    = free_id;
   assign accept          = hpu_cmd_valid_i && hpu_cmd_ready_o;
   assign out_fire        = out_valid_q && cmd_ready_i;
   assign out_id          = ID_W'(out_cmd_q.cmd_id.local_cmd_id);

   // Replace whatever cmd_id the HPU supplied with the system-wide id of
   // the slot being allocated.
   always_comb begin
      stamped_cmd                     = hpu_cmd_i;
      stamped_cmd.cmd_id.cluster_id   = MY_CLUSTER;
      stamped_cmd.cmd_id.core_id      = MY_CORE;
      stamped_cmd.cmd_id.local_cmd_id = local_id_t'(free_id);
   end

   // Responses are broadcast to every core, so anything addressed to
   // another core or cluster is dropped without comment. A response for
   // this core may only free a slot that is allocated and has already left
   // the output register; anything else is reported as spurious and leaves
   // the slot state untouched.
   always_comb begin
      resp_id     = ID_W'(resp_i.cmd_id.local_cmd_id);
      resp_match  = resp_valid_i
                    && (resp_i.cmd_id.cluster_id == MY_CLUSTER)
                    && (resp_i.cmd_id.core_id == MY_CORE);
      resp_in_out = out_valid_q && (out_id == resp_id);
      resp_free   = resp_match && alloc_q[resp_id] && !resp_in_out;
      resp_err    = resp_match && !resp_free;
   end

   // Next slot state. Releases only touch allocated slots and the accept
   // only touches a free one, so a response release, a no-event release and
   // a new allocation landing in the same cycle never collide.
   always_comb begin
      alloc_d = alloc_q;
      if (resp_free) begin
         alloc_d[resp_id] = 1'b0;
      end
      if (out_fire && out_noevt_q) begin
         alloc_d[out_id] = 1'b0;
      end
      if (accept) begin
         alloc_d[free_id] = 1'b1;
      end
   end

   // Slot, output register and error pulse state. The output register is
   // loaded on accept and otherwise holds its command steady until the
   // command unit takes it. Reset drops any pending command, so the command
   // unit has to be reset alongside this block.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alloc_q     <= '0;
         out_valid_q <= 1'b0;
         out_noevt_q <= 1'b0;
         out_cmd_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         alloc_q <= alloc_d;
         err_q   <= resp_err;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_cmd_q   <= stamped_cmd;
            out_noevt_q <= !hpu_cmd_i.generate_event;
         end else if (out_fire) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Population count of the allocated slots for the driver's status read.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < NUM_HPU_CMDS; i++) begin
         inflight = inflight + CNT_W'(alloc_q[i]);
      end
   end

   assign cmd_valid_o    = out_valid_q;
   assign cmd_o          = out_cmd_q;
   assign check_done_o   = ~alloc_q[check_id_i];
   assign busy_o         = |alloc_q;
   assign num_inflight_o = inflight;
   assign err_spurious_o = err_q;

endmodule
